fft_iter_core: RTL and testbench

- Parametrised, iterative radix-2 DIT FFT/IFFT core; successor to the fixed 8-point parallel FFT wrapper.
- Samples stream in serially through a valid/ready port and are stored in an internal complex buffer.
- One butterfly per cycle transforms the buffer in place; results stream out in natural order.
- Adds runtime inverse mode, optional per-stage 1/2 scaling and output backpressure.

---
 rtl/fft_iter_core_if.sv | 27 ++
 rtl/fft_iter_core.sv | 188 ++++++++++++++++++
 tb/tb_fft_iter_core.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_iter_core_if.sv
// Streaming sample interface for the iterative FFT core.
// The slave side is the core. The master side is the upstream source plus the downstream sink.
interface fft_iter_core_if #(
  parameter int DW = 16
);
  logic                 inverse;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic                 out_last;
  logic                 busy;

  modport master (
    output inverse, in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_last, busy
  );

  modport slave (
    input  inverse, in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_last, busy
  );
endinterface

// File: rtl/fft_iter_core.sv
// Iterative radix-2 DIT FFT/IFFT core.
// Samples are loaded in bit-reversed order into an in-place complex buffer.
// The core then runs one butterfly per cycle over log2(N_PTS) stages.
// Results are unloaded in natural order under valid/ready flow control.
module fft_iter_core #(
  parameter int N_PTS = 8,
  parameter int DW    = 16,
  parameter int TW_W  = 16,
  parameter int SCALE = 0
) (
  input  logic           CLK,
  input  logic           RST,
  fft_iter_core_if.slave bus
);

  localparam int  LOG2   = $clog2(N_PTS);
  localparam int  AW     = LOG2;
  localparam int  HW     = LOG2 - 1;
  localparam int  PW     = DW + TW_W + 1;
  localparam real TW_ONE = 2.0 ** (TW_W - 2);
  localparam real PI     = 3.14159265358979323846;

  function automatic int round_real(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] stage_q;
  logic [HW-1:0] bf_q;
  logic          inv_q;

  logic signed [DW-1:0] buf_re [N_PTS];
  logic signed [DW-1:0] buf_im [N_PTS];

  logic signed [TW_W-1:0] tw_cos [N_PTS/2];
  logic signed [TW_W-1:0] tw_sin [N_PTS/2];

  // Twiddle ROM: W_N^k = cos - j*sin, rounded to Q2.(TW_W-2) at elaboration
  for (genvar k = 0; k < N_PTS/2; k++) begin : g_tw
    localparam real ANG = 2.0 * PI * real'(k) / real'(N_PTS);
    assign tw_cos[k] = TW_W'(round_real($cos(ANG) * TW_ONE));
    assign tw_sin[k] = TW_W'(round_real($sin(ANG) * TW_ONE));
  end

  logic          last_sample;
  logic          last_bf;
  logic          last_stage;
  logic [AW-1:0] half, pos, top, bot;
  logic [HW-1:0] tw_idx;
  logic signed [TW_W-1:0] wr, wi;
  logic signed [DW-1:0]   a_re, a_im, b_re, b_im;
  logic signed [PW-1:0]   pr, pi;
  logic signed [DW:0]     wb_re, wb_im, s_re, s_im, d_re, d_im;
  logic signed [DW-1:0]   top_re, top_im, bot_re, bot_im;

  assign last_sample = (cnt_q == AW'(N_PTS - 1));
  assign last_bf     = (bf_q == '1);
  assign last_stage  = (stage_q == AW'(LOG2 - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (bus.in_valid && last_sample) state_d = COMPUTE;
      COMPUTE: if (last_bf && last_stage)       state_d = UNLOAD;
      UNLOAD:  if (bus.out_ready && last_sample) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Port outputs, decoded from state and the shared load/unload index
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_real  = '0;
    bus.out_imag  = '0;
    unique case (state_q)
      LOAD:    bus.in_ready = 1'b1;
      COMPUTE: bus.busy     = 1'b1;
      UNLOAD: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_last  = last_sample;
        bus.out_real  = buf_re[cnt_q];
        bus.out_imag  = buf_im[cnt_q];
      end
      default: ;
    endcase
  end

  // Counters: the sample index is shared by load and unload, and the stage/butterfly pair steps through compute
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      stage_q <= '0;
      bf_q    <= '0;
      inv_q   <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: if (bus.in_valid) begin
          if (cnt_q == '0) inv_q <= bus.inverse;
          cnt_q <= cnt_q + AW'(1);
        end
        COMPUTE: begin
          bf_q <= bf_q + HW'(1);
          if (last_bf) stage_q <= last_stage ? '0 : stage_q + AW'(1);
        end
        UNLOAD: if (bus.out_ready) cnt_q <= cnt_q + AW'(1);
        default: ;
      endcase
    end
  end

  // Butterfly datapath: address generation, twiddle lookup, complex multiply and sum/difference
  always_comb begin
    // Butterfly j of stage s: pairs are half=2^s apart, and groups are 2*half wide.
    // This gives top = (j/half)*2*half + j%half and twiddle index k = (j%half)*N/(2*half).
    half   = AW'(1) << stage_q;
    pos    = AW'(bf_q) & (half - AW'(1));
    top    = ((AW'(bf_q) >> stage_q) << (stage_q + AW'(1))) | pos;
    bot    = top | half;
    tw_idx = HW'(pos << (AW'(HW) - stage_q));

    wr = tw_cos[tw_idx];
    wi = inv_q ? tw_sin[tw_idx] : -tw_sin[tw_idx];

    a_re = buf_re[top];
    a_im = buf_im[top];
    b_re = buf_re[bot];
    b_im = buf_im[bot];

    pr = PW'(b_re) * PW'(wr) - PW'(b_im) * PW'(wi);
    pi = PW'(b_re) * PW'(wi) + PW'(b_im) * PW'(wr);
    wb_re = (DW+1)'(pr >>> (TW_W - 2));
    wb_im = (DW+1)'(pi >>> (TW_W - 2));

    s_re = (DW+1)'(a_re) + wb_re;
    s_im = (DW+1)'(a_im) + wb_im;
    d_re = (DW+1)'(a_re) - wb_re;
    d_im = (DW+1)'(a_im) - wb_im;

    if (SCALE != 0) begin
      top_re = DW'(s_re >>> 1);
      top_im = DW'(s_im >>> 1);
      bot_re = DW'(d_re >>> 1);
      bot_im = DW'(d_im >>> 1);
    end else begin
      top_re = DW'(s_re);
      top_im = DW'(s_im);
      bot_re = DW'(d_re);
      bot_im = DW'(d_im);
    end
  end

  // Buffer writes: bit-reversed load, in-place butterfly writeback
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == LOAD && bus.in_valid) begin
        buf_re[bitrev(cnt_q)] <= bus.in_real;
        buf_im[bitrev(cnt_q)] <= bus.in_imag;
      end else if (state_q == COMPUTE) begin
        buf_re[top] <= top_re;
        buf_im[top] <= top_im;
        buf_re[bot] <= bot_re;
        buf_im[bot] <= bot_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_iter_core.sv
// Testbench for fft_iter_core.
// Two instances are used: one with SCALE=0 and one with SCALE=1.
// Expected bins are queued when a frame is driven and consumed on output handshakes.
module tb_fft_iter_core;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int                 sel       = 0;
  logic               inverse   = 1'b0;
  logic               in_valid  = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] in_re     = '0;
  logic signed [15:0] in_im     = '0;

  fft_iter_core_if #(.DW(16)) bus0 ();
  fft_iter_core_if #(.DW(16)) bus1 ();

  assign bus0.inverse   = inverse;
  assign bus0.in_valid  = in_valid && (sel == 0);
  assign bus0.in_real   = in_re;
  assign bus0.in_imag   = in_im;
  assign bus0.out_ready = out_ready && (sel == 0);
  assign bus1.inverse   = inverse;
  assign bus1.in_valid  = in_valid && (sel == 1);
  assign bus1.in_real   = in_re;
  assign bus1.in_imag   = in_im;
  assign bus1.out_ready = out_ready && (sel == 1);

  fft_iter_core #(.N_PTS(8), .DW(16), .TW_W(16), .SCALE(0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  fft_iter_core #(.N_PTS(8), .DW(16), .TW_W(16), .SCALE(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  logic               o_in_ready, o_valid, o_last, o_busy;
  logic signed [15:0] o_re, o_im;
  assign o_in_ready = (sel == 1) ? bus1.in_ready  : bus0.in_ready;
  assign o_valid    = (sel == 1) ? bus1.out_valid : bus0.out_valid;
  assign o_last     = (sel == 1) ? bus1.out_last  : bus0.out_last;
  assign o_busy     = (sel == 1) ? bus1.busy      : bus0.busy;
  assign o_re       = (sel == 1) ? bus1.out_real  : bus0.out_real;
  assign o_im       = (sel == 1) ? bus1.out_imag  : bus0.out_imag;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {int re; int im; int tol; bit last;} exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    n_checks++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_frame(input int s, input bit inv, input int xr[8], input int er[8],
                           input int ei[8], input int et[8], input bit toggle, input bit collect);
    int lat, hs, guard, held_re, held_im;
    bit stalled;
    sel     = s;
    inverse = inv;
    if (collect)
      for (int i = 0; i < 8; i++) sb.push_back('{er[i], ei[i], et[i], (i == 7)});
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        in_valid = 1'b0;
        tick();
      end
      in_re    = 16'(xr[i]);
      in_im    = '0;
      in_valid = 1'b1;
      guard    = 0;
      while (!o_in_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) check("in_ready_timeout", guard, 0);
      tick();
    end
    in_valid = 1'b0;
    check("in_ready_drop", int'(o_in_ready), 0);
    check("busy_compute", int'(o_busy), 1);
    if (!collect) return;

    lat = 1;
    while (!o_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("latency", lat, 13);

    hs = 0; stalled = 1'b0; guard = 0; held_re = 0; held_im = 0;
    while (sb.size() > 0 && guard < 200) begin
      if (stalled) begin
        check($sformatf("hold%0d_re", hs), int'(o_re), held_re);
        check($sformatf("hold%0d_im", hs), int'(o_im), held_im);
      end
      out_ready = toggle ? ~out_ready : 1'b1;
      if (o_valid && out_ready) begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("bin%0d_re", hs), int'(o_re), e.re, e.tol);
        check($sformatf("bin%0d_im", hs), int'(o_im), e.im, e.tol);
        check($sformatf("bin%0d_last", hs), int'(o_last), int'(e.last));
        check($sformatf("bin%0d_in_ready", hs), int'(o_in_ready), 0);
        hs++;
        stalled = 1'b0;
      end else if (o_valid) begin
        stalled = 1'b1;
        held_re = int'(o_re);
        held_im = int'(o_im);
      end
      tick();
      guard++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    out_ready = 1'b0;
    check("handshakes", hs, 8);
    check("in_ready_after", int'(o_in_ready), 1);
    check("valid_after", int'(o_valid), 0);
  endtask

  int xr[8], er[8], ei[8], et[8];

  initial begin
    RST = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", int'(o_in_ready), 1);
    check("rst_out_valid", int'(o_valid), 0);
    check("rst_out_last", int'(o_last), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_out_real", int'(o_re), 0);
    check("rst_out_imag", int'(o_im), 0);
    RST = 1'b0;
    tick();

    // Impulse
    xr = '{1000, 0, 0, 0, 0, 0, 0, 0};
    er = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    et = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, 1'b0, xr, er, ei, et, 1'b0, 1'b1);

    // DC
    xr = '{100, 100, 100, 100, 100, 100, 100, 100};
    er = '{800, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, 1'b0, xr, er, ei, et, 1'b0, 1'b1);

    // Half-step: the non-trivial bins carry rounded/truncated twiddle error
    xr = '{50, 50, 50, 50, 0, 0, 0, 0};
    er = '{200, 50, 0, 50, 0, 50, 0, 50};
    ei = '{0, -121, 0, -21, 0, 21, 0, 121};
    et = '{0, 2, 0, 2, 0, 2, 0, 2};
    run_frame(0, 1'b0, xr, er, ei, et, 1'b0, 1'b1);

    // Inverse with scaling, then without
    xr = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    er = '{1000, 0, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    et = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(1, 1'b1, xr, er, ei, et, 1'b0, 1'b1);
    er = '{8000, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, 1'b1, xr, er, ei, et, 1'b0, 1'b1);

    // Backpressure on impulse
    xr = '{1000, 0, 0, 0, 0, 0, 0, 0};
    er = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    run_frame(0, 1'b0, xr, er, ei, et, 1'b1, 1'b1);

    // Reset during stage 2 discards the frame
    xr = '{100, 100, 100, 100, 100, 100, 100, 100};
    run_frame(0, 1'b0, xr, er, ei, et, 1'b0, 1'b0);
    repeat (5) tick();
    check("mid_busy", int'(o_busy), 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_in_ready", int'(o_in_ready), 1);
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_out_valid", int'(o_valid), 0);
    er = '{800, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, 1'b0, xr, er, ei, et, 1'b0, 1'b1);

    // Wrap: 8*0x7FFF keeps the low 16 bits, which are 0xFFF8
    xr = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    er = '{-8, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, 1'b0, xr, er, ei, et, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
